// File: rtl/serial_seq_gen.sv
// Serial bit-stream generator: shifts a loaded pattern out MSB-first (load_repeat+1) copies
// back-to-back and keeps a saturating count of every overlapping '101' it emits.
module serial_seq_gen #(
  parameter int WIDTH    = 8,
  parameter int REPEAT_W = 4,
  parameter int CNT_W    = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load_valid,
  output logic                load_ready,
  input  logic [WIDTH-1:0]    load_data,
  input  logic [REPEAT_W-1:0] load_repeat,
  output logic                x,
  output logic                x_valid,
  output logic                frame_start,
  output logic                done,
  output logic [CNT_W-1:0]    match_cnt
);

  localparam int IDX_W = $clog2(WIDTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_DONE
  } state_t;

  state_t              state;
  logic [WIDTH-1:0]    shreg;
  logic [WIDTH-1:0]    saved;
  logic [REPEAT_W-1:0] rep_left;
  logic [IDX_W-1:0]    bit_idx;
  logic [1:0]          hist;

  // x always mirrors shreg[WIDTH-1] while shifting, so the bit being emitted this
  // cycle is x itself; the history/match update below looks at that bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      shreg       <= '0;
      saved       <= '0;
      rep_left    <= '0;
      bit_idx     <= '0;
      hist        <= 2'b00;
      load_ready  <= 1'b1;
      x           <= 1'b0;
      x_valid     <= 1'b0;
      frame_start <= 1'b0;
      done        <= 1'b0;
      match_cnt   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          done <= 1'b0;
          if (load_valid && load_ready) begin
            shreg       <= load_data;
            saved       <= load_data;
            rep_left    <= load_repeat;
            bit_idx     <= LAST_IDX;
            hist        <= 2'b00;
            match_cnt   <= '0;
            load_ready  <= 1'b0;
            x           <= load_data[WIDTH-1];
            x_valid     <= 1'b1;
            frame_start <= 1'b1;
            state       <= ST_SHIFT;
          end
        end

        ST_SHIFT: begin
          hist <= {hist[0], x};
          if (x && (hist == 2'b10) && (match_cnt != {CNT_W{1'b1}}))
            match_cnt <= match_cnt + 1'b1;

          if (bit_idx == '0) begin
            if (rep_left == '0) begin
              x           <= 1'b0;
              x_valid     <= 1'b0;
              frame_start <= 1'b0;
              done        <= 1'b1;
              state       <= ST_DONE;
            end else begin
              // Next copy starts immediately: no idle bit between copies.
              shreg       <= saved;
              x           <= saved[WIDTH-1];
              frame_start <= 1'b1;
              bit_idx     <= LAST_IDX;
              rep_left    <= rep_left - 1'b1;
            end
          end else begin
            shreg       <= shreg << 1;
            x           <= shreg[WIDTH-2];
            frame_start <= 1'b0;
            bit_idx     <= bit_idx - 1'b1;
          end
        end

        ST_DONE: begin
          done       <= 1'b0;
          load_ready <= 1'b1;
          state      <= ST_IDLE;
        end

        default: begin
          state      <= ST_IDLE;
          load_ready <= 1'b1;
          x          <= 1'b0;
          x_valid    <= 1'b0;
          done       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_seq_gen.sv
// Directed bench for serial_seq_gen: a table of jobs with hand-computed '101' counts,
// plus hand-written reset-abort and held-valid sequences; a CNT_W=5 copy checks saturation.
module tb_serial_seq_gen;

  logic       clk;
  logic       rst;
  logic       load_valid;
  logic [7:0] load_data;
  logic [3:0] load_repeat;

  logic       load_ready, x, x_valid, frame_start, done;
  logic [7:0] match_cnt;
  logic       s_load_ready, s_x, s_x_valid, s_frame_start, s_done;
  logic [4:0] s_match_cnt;

  int checks = 0;
  int errors = 0;

  serial_seq_gen #(.WIDTH(8), .REPEAT_W(4), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .load_valid(load_valid), .load_ready(load_ready),
    .load_data(load_data), .load_repeat(load_repeat), .x(x), .x_valid(x_valid),
    .frame_start(frame_start), .done(done), .match_cnt(match_cnt)
  );

  serial_seq_gen #(.WIDTH(8), .REPEAT_W(4), .CNT_W(5)) dut_sat (
    .clk(clk), .rst(rst), .load_valid(load_valid), .load_ready(s_load_ready),
    .load_data(load_data), .load_repeat(load_repeat), .x(s_x), .x_valid(s_x_valid),
    .frame_start(s_frame_start), .done(s_done), .match_cnt(s_match_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    logic [3:0] rep;
    logic       hold;     // keep load_valid high through the whole job
    int         exp_cnt;  // hand-counted overlapping '101's in the stream
  } vec_t;

  vec_t tbl[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Called at a negedge with the DUT idle; returns at the negedge of cycle k+N+2.
  task automatic run_job(input int id, input vec_t v);
    int         n;
    int         zc;
    logic [1:0] dh;
    logic       bitv;
    n  = 8 * (int'(v.rep) + 1);
    zc = 0;
    dh = 2'b00;
    chk($sformatf("job%0d ready_before", id), {31'd0, load_ready}, 32'd1);
    load_valid  = 1'b1;
    load_data   = v.data;
    load_repeat = v.rep;
    @(negedge clk);
    if (v.hold) load_data = ~v.data;
    else        load_valid = 1'b0;
    for (int i = 0; i < n; i++) begin
      bitv = v.data[7 - (i % 8)];
      // {load_ready, x_valid, x, frame_start, done}
      chk($sformatf("job%0d bit%0d", id, i),
          {27'd0, load_ready, x_valid, x, frame_start, done},
          {27'd0, 1'b0, 1'b1, bitv, (i % 8) == 0, 1'b0});
      if (s_x_valid) begin
        if (s_x && dh == 2'b10) zc++;
        dh = {dh[0], s_x};
      end
      @(negedge clk);
    end
    chk($sformatf("job%0d done_cycle", id),
        {28'd0, load_ready, x_valid, x, done}, {28'd0, 1'b0, 1'b0, 1'b0, 1'b1});
    @(negedge clk);
    chk($sformatf("job%0d ready_after", id), {30'd0, load_ready, done}, {30'd0, 1'b1, 1'b0});
    chk($sformatf("job%0d match_cnt", id), {24'd0, match_cnt}, v.exp_cnt);
    chk($sformatf("job%0d sat_cnt", id), {27'd0, s_match_cnt},
        (v.exp_cnt > 31) ? 32'd31 : v.exp_cnt);
    chk($sformatf("job%0d detector_z", id), zc, v.exp_cnt);
  endtask

  initial begin
    tbl[0] = '{data: 8'b1010_1101, rep: 4'd0,  hold: 1'b0, exp_cnt: 3};
    tbl[1] = '{data: 8'b1000_0010, rep: 4'd1,  hold: 1'b0, exp_cnt: 1};
    tbl[2] = '{data: 8'b0101_0101, rep: 4'd0,  hold: 1'b1, exp_cnt: 3};
    tbl[3] = '{data: 8'b1011_0101, rep: 4'd1,  hold: 1'b0, exp_cnt: 6};
    tbl[4] = '{data: 8'b0000_0101, rep: 4'd2,  hold: 1'b0, exp_cnt: 3};
    tbl[5] = '{data: 8'hAA,        rep: 4'd15, hold: 1'b0, exp_cnt: 63};
    tbl[6] = '{data: 8'hFF,        rep: 4'd15, hold: 1'b0, exp_cnt: 0};

    rst         = 1'b1;
    load_valid  = 1'b0;
    load_data   = 8'h00;
    load_repeat = 4'd0;
    repeat (2) @(negedge clk);
    chk("reset_outputs", {25'd0, load_ready, x, x_valid, frame_start, done, 2'b00},
        {25'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00});
    chk("reset_cnt", {24'd0, match_cnt}, 32'd0);
    // Offers during reset must not start a job.
    load_valid = 1'b1;
    load_data  = 8'hFF;
    @(negedge clk);
    chk("reset_wins", {30'd0, x_valid, load_ready}, {30'd0, 1'b0, 1'b1});
    load_valid = 1'b0;
    rst        = 1'b0;
    @(negedge clk);

    // Job 2 is held-valid, so job 3 is accepted the very cycle ready returns.
    for (int j = 0; j < 7; j++) run_job(j, tbl[j]);
    load_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("cnt_holds_idle", {24'd0, match_cnt}, 32'd0);

    // Reset during the 4th bit of an 8'hAA job aborts it without a done pulse.
    load_valid  = 1'b1;
    load_data   = 8'hAA;
    load_repeat = 4'd0;
    @(negedge clk);
    load_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("abort_pre_state", {23'd0, x_valid, x, match_cnt}, {23'd0, 1'b1, 1'b0, 8'd1});
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_outputs", {27'd0, load_ready, x_valid, x, frame_start, done},
        {27'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0});
    chk("abort_cnt", {24'd0, match_cnt}, 32'd0);
    begin
      int pulses;
      pulses = 0;
      for (int i = 0; i < 12; i++) begin
        if (done || x_valid) pulses++;
        @(negedge clk);
      end
      chk("abort_no_done", pulses, 32'd0);
    end

    // After an abort the block must take a fresh job normally.
    run_job(7, tbl[0]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
